seq_det_ctrl: RTL and testbench

SEQ_DET_CTRL -- requirements
Module: seq_det_ctrl

---
 rtl/seq_det_ctrl.sv | 157 +++++++++++++++
 tb/tb_seq_det_ctrl.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/seq_det_ctrl.sv
// seq_det_ctrl -- serial 4-bit pattern detector with run control.
//
// A run is armed with start, consumes din on din_valid cycles, and pulses
// match (registered, one cycle after the completing bit) whenever the last
// four accepted bits equal the configured pattern. When a non-zero
// threshold is reached, done pulses together with that match and the FSM
// passes through a one-cycle DONE state back to IDLE.
//
// Optional build macro: SEQ_DET_NONOVERLAP_EN
//   defined   -> a match clears history/fill (non-overlapping detection)
//   undefined -> history is kept after a match (overlapping detection)
//
// Ports:
//   clk            in   rising-edge clock
//   rst            in   asynchronous, active-low reset
//   start          in   arm detection (IDLE only)
//   stop           in   abort detection (RUN only), beats a same-cycle bit
//   cfg_we         in   load cfg_pattern/cfg_threshold (IDLE only)
//   cfg_pattern    in   [3:0] target sequence, bit 3 = oldest bit
//   cfg_threshold  in   [CNT_W-1:0] matches that end a run, 0 = unlimited
//   din_valid      in   din is sampled this cycle
//   din            in   serial data bit
//   busy           out  high while in RUN
//   match          out  one-cycle pulse per detected pattern
//   match_count    out  [CNT_W-1:0] saturating matches since last start
//   done           out  one-cycle pulse when the threshold is reached
module seq_det_ctrl #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             cfg_we,
  input  logic [3:0]       cfg_pattern,
  input  logic [CNT_W-1:0] cfg_threshold,
  input  logic             din_valid,
  input  logic             din,
  output logic             busy,
  output logic             match,
  output logic [CNT_W-1:0] match_count,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [3:0]       PAT_RESET = 4'b1010;

  state_t           state_reg, state_next;
  logic [3:0]       pattern_reg, pattern_next;
  logic [CNT_W-1:0] threshold_reg, threshold_next;
  logic [3:0]       hist_reg, hist_next;
  logic [2:0]       fill_reg, fill_next;
  logic [CNT_W-1:0] count_reg, count_next;
  logic             match_reg, match_next;
  logic             done_reg, done_next;

  // Candidate post-shift values for the current din_valid cycle.
  logic [3:0]       hist_shift;
  logic [2:0]       fill_inc;
  logic [CNT_W-1:0] count_inc;

  assign hist_shift = {hist_reg[2:0], din};
  assign fill_inc   = (fill_reg == 3'd4) ? 3'd4 : fill_reg + 3'd1;
  assign count_inc  = (count_reg == CNT_MAX) ? count_reg : count_reg + 1'b1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg     <= IDLE;
      pattern_reg   <= PAT_RESET;
      threshold_reg <= '0;
      hist_reg      <= '0;
      fill_reg      <= '0;
      count_reg     <= '0;
      match_reg     <= 1'b0;
      done_reg      <= 1'b0;
    end else begin
      state_reg     <= state_next;
      pattern_reg   <= pattern_next;
      threshold_reg <= threshold_next;
      hist_reg      <= hist_next;
      fill_reg      <= fill_next;
      count_reg     <= count_next;
      match_reg     <= match_next;
      done_reg      <= done_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    pattern_next   = pattern_reg;
    threshold_next = threshold_reg;
    hist_next      = hist_reg;
    fill_next      = fill_reg;
    count_next     = count_reg;
    match_next     = 1'b0;
    done_next      = 1'b0;

    case (state_reg)
      IDLE: begin
        if (cfg_we) begin
          pattern_next   = cfg_pattern;
          threshold_next = cfg_threshold;
        end
        // Config written in the same cycle lands on the same edge as the
        // transition, so the new run already sees the new values.
        if (start) begin
          state_next = RUN;
          hist_next  = '0;
          fill_next  = '0;
          count_next = '0;
        end
      end

      RUN: begin
        if (stop) begin
          // The same-cycle bit is dropped entirely.
          state_next = IDLE;
        end else if (din_valid) begin
          hist_next = hist_shift;
          fill_next = fill_inc;
          if ((fill_inc == 3'd4) && (hist_shift == pattern_reg)) begin
            match_next = 1'b1;
            count_next = count_inc;
`ifdef SEQ_DET_NONOVERLAP_EN
            hist_next  = '0;
            fill_next  = '0;
`endif
            if ((threshold_reg != '0) && (count_inc == threshold_reg)) begin
              state_next = DONE;
              done_next  = 1'b1;
            end
          end
        end
      end

      DONE: begin
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign busy        = (state_reg == RUN);
  assign match       = match_reg;
  assign done        = done_reg;
  assign match_count = count_reg;

endmodule

// File: tb/tb_seq_det_ctrl.sv
module tb_seq_det_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;

  // 8-bit counter instance
  logic       start = 1'b0, stop = 1'b0, cfg_we = 1'b0;
  logic [3:0] cfg_pattern = 4'b0000;
  logic [7:0] cfg_threshold = 8'd0;
  logic       din_valid = 1'b0, din = 1'b0;
  logic       busy, match, done;
  logic [7:0] match_count;

  // 2-bit counter instance for saturation
  logic       b_start = 1'b0, b_stop = 1'b0, b_cfg_we = 1'b0;
  logic [3:0] b_cfg_pattern = 4'b0000;
  logic [1:0] b_cfg_threshold = 2'd0;
  logic       b_din_valid = 1'b0, b_din = 1'b0;
  logic       b_busy, b_match, b_done;
  logic [1:0] b_match_count;

  int n_cmp = 0;
  int n_err = 0;

  seq_det_ctrl #(.CNT_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .cfg_we(cfg_we),
    .cfg_pattern(cfg_pattern), .cfg_threshold(cfg_threshold),
    .din_valid(din_valid), .din(din),
    .busy(busy), .match(match), .match_count(match_count), .done(done)
  );

  seq_det_ctrl #(.CNT_W(2)) dut_b (
    .clk(clk), .rst(rst), .start(b_start), .stop(b_stop), .cfg_we(b_cfg_we),
    .cfg_pattern(b_cfg_pattern), .cfg_threshold(b_cfg_threshold),
    .din_valid(b_din_valid), .din(b_din),
    .busy(b_busy), .match(b_match), .match_count(b_match_count), .done(b_done)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
      $display("check %-18s obs=%0h exp=%0h ok", tag, obs, exp);
    else begin
      n_err++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic b, input logic s);
    din_valid = 1'b1;
    din       = b;
    stop      = s;
    cyc();
    din_valid = 1'b0;
    stop      = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  // After a completed 1010 match: bits that leave the detector one '0'
  // away from the next match.
  task automatic pre_complete();
`ifdef SEQ_DET_NONOVERLAP_EN
    send(1'b1, 1'b0);
    send(1'b0, 1'b0);
    send(1'b1, 1'b0);
`else
    send(1'b1, 1'b0);
`endif
  endtask

  initial begin
    // ---------------- reset state ----------------
    cyc(); cyc();
    chk("rst_busy", busy, 0);
    chk("rst_match", match, 0);
    chk("rst_done", done, 0);
    chk("rst_count", match_count, 0);
    rst = 1'b1;
    cyc();

    // ---------------- 1010 default pattern, overlap/nonoverlap ----------------
    pulse_start();
    chk("s1_busy", busy, 1);
    chk("s1_count0", match_count, 0);
    send(1'b1, 1'b0); chk("s1_b1", match, 0);
    send(1'b0, 1'b0); chk("s1_b2", match, 0);
    cyc();            chk("s1_gap", match, 0);   // din_valid gap
    send(1'b1, 1'b0); chk("s1_b3", match, 0);
    send(1'b0, 1'b0); chk("s1_b4", match, 1);
    chk("s1_cnt4", match_count, 1);
    cyc();            chk("s1_pulse", match, 0);
    send(1'b1, 1'b0); chk("s1_b5", match, 0);
    send(1'b0, 1'b0);
`ifdef SEQ_DET_NONOVERLAP_EN
    chk("s1_b6", match, 0);
    chk("s1_cnt6", match_count, 1);
    send(1'b1, 1'b0); chk("s1_b7", match, 0);
    send(1'b0, 1'b0); chk("s1_b8", match, 1);
`else
    chk("s1_b6", match, 1);
`endif
    chk("s1_cnt", match_count, 2);
    start = 1'b1; cyc(); start = 1'b0;           // start in RUN ignored
    chk("s1_start_ign", match_count, 2);
    stop = 1'b1; cyc(); stop = 1'b0;
    chk("s1_stop_busy", busy, 0);
    cyc();
    chk("s1_idle_hold", match_count, 2);

    // ---------------- 1101 threshold 2, config with start ----------------
    cfg_we = 1'b1; cfg_pattern = 4'b1101; cfg_threshold = 8'd2;
    start = 1'b1;
    cyc();
    cfg_we = 1'b0; start = 1'b0;
    chk("s2_busy", busy, 1);
    chk("s2_cnt0", match_count, 0);
    send(1'b1, 1'b0); send(1'b1, 1'b0); send(1'b0, 1'b0);
    chk("s2_b3", match, 0);
    send(1'b1, 1'b0);
    chk("s2_b4", match, 1);
    chk("s2_b4_done", done, 0);
    chk("s2_cnt1", match_count, 1);
`ifdef SEQ_DET_NONOVERLAP_EN
    send(1'b1, 1'b0); send(1'b1, 1'b0); send(1'b0, 1'b0);
`else
    send(1'b1, 1'b0); send(1'b0, 1'b0);
`endif
    chk("s2_prelast", match, 0);
    send(1'b1, 1'b0);
    chk("s2_match2", match, 1);
    chk("s2_done", done, 1);
    chk("s2_busy_done", busy, 0);
    chk("s2_cnt2", match_count, 2);
    // start and a bit during DONE are ignored
    start = 1'b1; din_valid = 1'b1; din = 1'b1;
    cyc();
    start = 1'b0; din_valid = 1'b0;
    chk("s2_idle_busy", busy, 0);
    chk("s2_done_pulse", done, 0);
    chk("s2_match_pulse", match, 0);
    cyc();
    chk("s2_still_idle", busy, 0);

    // ---------------- stop beats completing bit ----------------
    cfg_we = 1'b1; cfg_pattern = 4'b1010; cfg_threshold = 8'd0;
    cyc();
    cfg_we = 1'b0;
    pulse_start();
    chk("s3_cnt0", match_count, 0);
    send(1'b1, 1'b0); send(1'b0, 1'b0); send(1'b1, 1'b0); send(1'b0, 1'b0);
    chk("s3_cnt1", match_count, 1);
    pre_complete();
    send(1'b0, 1'b1);
    chk("s3_stop_match", match, 0);
    chk("s3_stop_busy", busy, 0);
    chk("s3_stop_cnt", match_count, 1);

    // ---------------- cfg_we in RUN ignored, reset mid-run ----------------
    pulse_start();
    cfg_we = 1'b1; cfg_pattern = 4'b0000; cfg_threshold = 8'd1;
    cyc();
    cfg_we = 1'b0;
    send(1'b0, 1'b0); send(1'b0, 1'b0); send(1'b0, 1'b0); send(1'b0, 1'b0);
    chk("s4_zero_nomatch", match, 0);
    send(1'b1, 1'b0); send(1'b0, 1'b0); send(1'b1, 1'b0); send(1'b0, 1'b0);
    chk("s4_orig_match", match, 1);
    chk("s4_no_done", done, 0);
    chk("s4_busy", busy, 1);
    pre_complete();
    din_valid = 1'b1; din = 1'b0;
    #2 rst = 1'b0;
    #1;
    chk("s4_arst_busy", busy, 0);
    chk("s4_arst_cnt", match_count, 0);
    cyc();
    din_valid = 1'b0;
    chk("s4_rst_match", match, 0);
    chk("s4_rst_done", done, 0);
    rst = 1'b1;
    cyc();
    pulse_start();
    send(1'b1, 1'b0); send(1'b0, 1'b0); send(1'b1, 1'b0); send(1'b0, 1'b0);
    chk("s4_pat_reset", match, 1);
    chk("s4_thr_reset", done, 0);
    stop = 1'b1; cyc(); stop = 1'b0;

    // ---------------- CNT_W=2 saturation ----------------
    b_cfg_we = 1'b1; b_cfg_pattern = 4'b0000; b_cfg_threshold = 2'd0;
    b_start = 1'b1;
    cyc();
    b_cfg_we = 1'b0; b_start = 1'b0;
    chk("s5_busy", b_busy, 1);
    b_din = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      b_din_valid = 1'b1; cyc();
    end
    b_din_valid = 1'b0;
    chk("s5_first", b_match_count, 1);
`ifdef SEQ_DET_NONOVERLAP_EN
    for (int i = 5; i <= 16; i++) begin
`else
    for (int i = 5; i <= 8; i++) begin
`endif
      b_din_valid = 1'b1; cyc();
    end
    b_din_valid = 1'b0;
    chk("s5_sat_match", b_match, 1);
    chk("s5_sat", b_match_count, 3);
    chk("s5_no_done", b_done, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
